// File: rtl/pose_sched_if.sv
// DTW engine link: scheduler (master) streams camera/reference angle pairs,
// the engine (slave) applies backpressure and returns one score per channel.
interface pose_sched_if #(
  parameter int unsigned ANGLE_DEPTH = 32,
  parameter int unsigned SCORE_W     = 32
);
  logic                   dtw_start;
  logic                   dtw_valid;
  logic                   dtw_ready;
  logic [ANGLE_DEPTH-1:0] dtw_camera;
  logic [ANGLE_DEPTH-1:0] dtw_refer;
  logic                   dtw_done;
  logic [SCORE_W-1:0]     dtw_score;

  modport master (
    output dtw_start, dtw_valid, dtw_camera, dtw_refer,
    input  dtw_ready, dtw_done, dtw_score
  );

  modport slave (
    input  dtw_start, dtw_valid, dtw_camera, dtw_refer,
    output dtw_ready, dtw_done, dtw_score
  );
endinterface

// File: rtl/pose_sched.sv
// Buffers per-channel camera/reference angle sequences and feeds them, channel by
// channel, to an external DTW engine, collecting per-channel and saturated total scores.
module pose_sched #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned ANGLE_DEPTH = 32,
  parameter int unsigned SIZE        = 22,
  parameter int unsigned SCORE_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cam_wr,
  input  logic [$clog2(CHANNELS)-1:0] cam_ch,
  input  logic [ANGLE_DEPTH-1:0]      cam_in,
  input  logic                        ref_wr,
  input  logic [$clog2(CHANNELS)-1:0] ref_ch,
  input  logic [ANGLE_DEPTH-1:0]      ref_in,
  input  logic                        ref_clr,
  input  logic                        start,
  pose_sched_if.master                dtw,
  output logic                        score_valid,
  output logic [$clog2(CHANNELS)-1:0] score_idx,
  output logic [SCORE_W-1:0]          score_ch,
  output logic [SCORE_W-1:0]          score_total,
  output logic                        busy,
  output logic                        done,
  output logic                        err_start,
  output logic                        err_ovf
);

  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CH_W-1:0]        c;
  logic [IDX_W-1:0]       i;

  logic [ANGLE_DEPTH-1:0] cam_mem [CHANNELS][SIZE];
  logic [ANGLE_DEPTH-1:0] ref_mem [CHANNELS][SIZE];
  logic [CNT_W-1:0]       cam_cnt [CHANNELS];
  logic [CNT_W-1:0]       ref_cnt [CHANNELS];

  logic                   cam_ch_ok;
  logic                   ref_ch_ok;
  logic [CNT_W-1:0]       cam_sel_cnt;
  logic [CNT_W-1:0]       ref_sel_cnt;
  logic                   cam_acc;
  logic                   ref_acc;
  logic [IDX_W-1:0]       cam_wr_idx;
  logic [IDX_W-1:0]       ref_wr_idx;
  logic                   all_full;
  logic [SCORE_W:0]       sum_wide;
  logic [SCORE_W-1:0]     sum_sat;
  logic [IDX_W-1:0]       i_nxt;

  // Write acceptance, start qualification and saturating score sum
  always_comb begin
    cam_ch_ok   = 32'(cam_ch) < CHANNELS;
    ref_ch_ok   = 32'(ref_ch) < CHANNELS;
    cam_sel_cnt = cam_ch_ok ? cam_cnt[cam_ch] : '0;
    ref_sel_cnt = ref_ch_ok ? ref_cnt[ref_ch] : '0;
    cam_acc     = cam_wr && (state == S_IDLE) && cam_ch_ok && (cam_sel_cnt < CNT_W'(SIZE));
    // A clear in the same cycle as a reference write restarts the channel at slot 0
    ref_acc     = ref_wr && (state == S_IDLE) && ref_ch_ok &&
                  (ref_clr || (ref_sel_cnt < CNT_W'(SIZE)));
    cam_wr_idx  = IDX_W'(cam_sel_cnt);
    ref_wr_idx  = ref_clr ? '0 : IDX_W'(ref_sel_cnt);
    all_full    = 1'b1;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if ((cam_cnt[k] != CNT_W'(SIZE)) || (ref_cnt[k] != CNT_W'(SIZE))) all_full = 1'b0;
    end
    sum_wide    = {1'b0, score_total} + {1'b0, dtw.dtw_score};
    sum_sat     = sum_wide[SCORE_W] ? '1 : sum_wide[SCORE_W-1:0];
    i_nxt       = i + IDX_W'(1);
  end

  // Sample storage; contents survive reset, only the counts are cleared
  always_ff @(posedge clk) begin
    if (cam_acc) cam_mem[cam_ch][cam_wr_idx] <= cam_in;
    if (ref_acc) ref_mem[ref_ch][ref_wr_idx] <= ref_in;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      c              <= '0;
      i              <= '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        cam_cnt[k] <= '0;
        ref_cnt[k] <= '0;
      end
      dtw.dtw_start  <= 1'b0;
      dtw.dtw_valid  <= 1'b0;
      dtw.dtw_camera <= '0;
      dtw.dtw_refer  <= '0;
      score_valid    <= 1'b0;
      score_idx      <= '0;
      score_ch       <= '0;
      score_total    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_start      <= 1'b0;
      err_ovf        <= 1'b0;
    end else begin
      dtw.dtw_start <= 1'b0;
      score_valid   <= 1'b0;
      done          <= 1'b0;
      err_start     <= 1'b0;

      if ((cam_wr && !cam_acc) || (ref_wr && !ref_acc)) err_ovf <= 1'b1;
      if (cam_acc) cam_cnt[cam_ch] <= cam_sel_cnt + CNT_W'(1);
      if ((state == S_IDLE) && ref_clr) begin
        for (int k = 0; k < int'(CHANNELS); k++) ref_cnt[k] <= '0;
      end
      if (ref_acc) ref_cnt[ref_ch] <= ref_clr ? CNT_W'(1) : ref_sel_cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (all_full) begin
              state         <= S_LAUNCH;
              c             <= '0;
              score_total   <= '0;
              busy          <= 1'b1;
              dtw.dtw_start <= 1'b1;
            end else begin
              err_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          i              <= '0;
          dtw.dtw_valid  <= 1'b1;
          dtw.dtw_camera <= cam_mem[c][0];
          dtw.dtw_refer  <= ref_mem[c][0];
          state          <= S_STREAM;
        end
        S_STREAM: begin
          if (dtw.dtw_ready) begin
            if (i == IDX_W'(SIZE - 1)) begin
              dtw.dtw_valid <= 1'b0;
              state         <= S_WAIT;
            end else begin
              i              <= i_nxt;
              dtw.dtw_camera <= cam_mem[c][i_nxt];
              dtw.dtw_refer  <= ref_mem[c][i_nxt];
            end
          end
        end
        S_WAIT: begin
          if (dtw.dtw_done) begin
            score_ch    <= dtw.dtw_score;
            score_idx   <= c;
            score_valid <= 1'b1;
            score_total <= sum_sat;
            if (c == CH_W'(CHANNELS - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              c             <= c + CH_W'(1);
              state         <= S_LAUNCH;
              dtw.dtw_start <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Camera frames are consumed per run; the reference sequence is reusable
          for (int k = 0; k < int'(CHANNELS); k++) cam_cnt[k] <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pose_sched.md
POSE_SCHED -- requirements
Module: pose_sched

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent joint-angle channels scored per frame sequence.
REQ-002 Parameter ANGLE_DEPTH, default 32, bits per angle sample.
REQ-003 Parameter SIZE, default 22, samples per sequence per channel (camera and reference).
REQ-004 Parameter SCORE_W, default 32, bits of per-channel and total score.
REQ-005 Port clk  in  1  single clock; all logic on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port cam_wr  in  1  write one camera angle sample.
REQ-008 Port cam_ch  in  $clog2(CHANNELS)  channel of cam_wr sample.
REQ-009 Port cam_in  in  ANGLE_DEPTH  camera angle sample.
REQ-010 Port ref_wr  in  1  write one reference angle sample.
REQ-011 Port ref_ch  in  $clog2(CHANNELS)  channel of ref_wr sample.
REQ-012 Port ref_in  in  ANGLE_DEPTH  reference angle sample.
REQ-013 Port ref_clr  in  1  clear all reference counts.
REQ-014 Port start  in  1  request scoring of all channels.
REQ-015 Port dtw_start  out  1  one-cycle pulse: DTW engine begins a new channel.
REQ-016 Port dtw_valid / dtw_ready  out / in  1 / 1  pair handshake; transfer when both high.
REQ-017 Port dtw_camera / dtw_refer  out  ANGLE_DEPTH each  current sample pair.
REQ-018 Port dtw_done / dtw_score  in  1 / SCORE_W  engine finished channel; score valid same cycle.
REQ-019 Port score_valid / score_idx / score_ch  out  1 / $clog2(CHANNELS) / SCORE_W  per-channel result strobe.
REQ-020 Port score_total  out  SCORE_W  saturating sum of channel scores for current run.
REQ-021 Port busy / done / err_start / err_ovf  out  1 each  status; done and err_start are one-cycle pulses, err_ovf sticky.

Function
REQ-022 Per channel: camera buffer and reference buffer, SIZE entries each, write counters 0..SIZE.
REQ-023 cam_wr/ref_wr in IDLE with count<SIZE stores sample at index=count, count+1; at count==SIZE, sample dropped, err_ovf set.
REQ-024 cam_wr or ref_wr while busy: sample dropped, err_ovf set; ref_clr while busy ignored.
REQ-025 cam_ch/ref_ch >= CHANNELS: write dropped, err_ovf set.
REQ-026 FSM states IDLE, LAUNCH, STREAM, WAIT, DONE.
REQ-027 IDLE: start with every camera and reference count==SIZE -> LAUNCH, channel c=0, score_total=0; otherwise start ignored, err_start pulses next cycle.
REQ-028 LAUNCH: dtw_start high one cycle, sample index i=0 -> STREAM.
REQ-029 STREAM: dtw_valid=1, dtw_camera=cam[c][i], dtw_refer=ref[c][i]; held stable while dtw_ready=0; on transfer i+1; transfer of i==SIZE-1 -> WAIT.
REQ-030 WAIT: dtw_valid=0; on dtw_done, score_ch<=dtw_score, score_idx<=c, score_valid pulses next cycle, score_total<=min(score_total+dtw_score, 2^SCORE_W-1).
REQ-031 WAIT on dtw_done: c<CHANNELS-1 -> c+1, LAUNCH; c==CHANNELS-1 -> DONE.
REQ-032 dtw_done outside WAIT ignored.
REQ-033 DONE: done pulses one cycle, all camera counts cleared, reference counts retained, -> IDLE; score_total and score_ch hold until next accepted start.
REQ-034 busy=1 in LAUNCH, STREAM, WAIT, DONE; 0 in IDLE.
REQ-035 start while busy ignored, no err_start.
REQ-036 Sum uses SCORE_W+1 bit internal add; carry forces all-ones.

Reset
REQ-037 rst: state IDLE, c=0, i=0, all camera/reference counts 0, all outputs 0 (dtw_* outs, score_*, busy, done, err_start, err_ovf); buffer contents need not clear.
REQ-038 rst asserted mid-run aborts immediately; no done or score_valid pulse follows.

Verification (CHANNELS=3, SIZE=4, SCORE_W=32)
REQ-039 Reset: rst high 2 cycles -> all outputs 0, busy 0.
REQ-040 Full run: load 4 ref + 4 cam per channel, start, model returns 10,20,30 -> score_valid x3 idx 0,1,2, score_total=60, 3 dtw_start pulses, 12 pair transfers in channel/index order, done one pulse.
REQ-041 Incomplete start: channel 1 camera count 3, start -> err_start pulse, busy stays 0, no dtw_start.
REQ-042 Backpressure: dtw_ready toggles every cycle -> pairs stable while ready low, exactly 4 transfers per channel, no loss or duplication.
REQ-043 Saturation: scores 0xFFFF_FFF0, 0x20, 0x1 -> score_total=0xFFFF_FFFF.
REQ-044 Overflow and abort: 5th cam_wr to channel 0 -> err_ovf=1, count stays 4; rst in STREAM -> counts 0, no done pulse.
